// File: rtl/serial_subtractor_if.sv
// Handshake and data bundle for the bit-serial subtractor.
// Master side (requester) drives start/a/b/bin and observes busy/done/diff/bout.
// Slave side (the subtractor) takes the operands and returns status and result.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
) ();

  logic             start;  // request a subtraction, honoured only when idle
  logic [WIDTH-1:0] a;      // minuend
  logic [WIDTH-1:0] b;      // subtrahend
  logic             bin;    // borrow-in
  logic             busy;   // operation in progress
  logic             done;   // one-cycle pulse, result valid
  logic [WIDTH-1:0] diff;   // last completed (a - b - bin) mod 2^WIDTH
  logic             bout;   // last completed borrow-out

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );

endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, LSB first, one bit per clock.
// Latency WIDTH clocks from the accepting edge to done; one operation per WIDTH+1 clocks.
// No backpressure: start is sampled only in IDLE, start during RUN is dropped.
//
// Ports:
//   clk   - single rising-edge clock
//   rst_n - synchronous active-low reset, clears all state and outputs
//   io    - slave modport: start/a/b/bin in, busy/done/diff/bout out
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   io
);

  // Counter must be able to represent WIDTH itself so it never wraps early.
  localparam int              CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q,  a_sh_d;
  logic [WIDTH-1:0] b_sh_q,  b_sh_d;
  logic [WIDTH-1:0] r_sh_q,  r_sh_d;
  logic             br_q,    br_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             done_q,  done_d;
  logic [WIDTH-1:0] diff_q,  diff_d;
  logic             bout_q,  bout_d;

  // Single-bit full-subtractor slice operating on the current LSBs.
  logic x_bit;
  logic y_bit;
  logic d_bit;
  logic br_nxt;

  always_comb begin
    x_bit  = a_sh_q[0];
    y_bit  = b_sh_q[0];
    d_bit  = x_bit ^ y_bit ^ br_q;
    br_nxt = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & br_q);
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_sh_d  = r_sh_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    diff_d  = diff_q;
    bout_d  = bout_q;

    case (state_q)
      IDLE: begin
        if (io.start) begin
          a_sh_d  = io.a;
          b_sh_d  = io.b;
          br_d    = io.bin;
          r_sh_d  = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        // Result bits enter at the MSB and move right, so after WIDTH
        // shifts the first (LSB) result bit has reached bit 0.
        r_sh_d            = r_sh_q >> 1;
        r_sh_d[WIDTH-1]   = d_bit;
        br_d              = br_nxt;
        cnt_d             = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // Publish only the completed word; diff/bout never show partials.
          diff_d  = r_sh_d;
          bout_d  = br_nxt;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_sh_q  <= r_sh_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign io.busy = (state_q == RUN);
  assign io.done = done_q;
  assign io.diff = diff_q;
  assign io.bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor at WIDTH = 8, 1 and 16.
// Stimulus pushes expected {cycle, bout, diff} into per-instance queues;
// independent monitors pop and compare on every done pulse.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_subtractor_if #(.WIDTH(8))  if8  ();
  serial_subtractor_if #(.WIDTH(1))  if1  ();
  serial_subtractor_if #(.WIDTH(16)) if16 ();

  serial_subtractor #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .io(if8));
  serial_subtractor #(.WIDTH(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .io(if1));
  serial_subtractor #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .io(if16));

  typedef struct {
    int          cyc;
    logic        bout;
    logic [15:0] diff;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];
  exp_t q16[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h cyc=%0d", nm, act, req, cyc);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    exp_t e;
    if (if8.done === 1'b1) begin
      if (q8.size() == 0) begin
        chk("w8_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q8.pop_front();
        chk("w8_result", {23'd0, if8.bout, if8.diff}, {23'd0, e.bout, e.diff[7:0]});
        chk("w8_done_cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (if1.done === 1'b1) begin
      if (q1.size() == 0) begin
        chk("w1_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q1.pop_front();
        chk("w1_result", {30'd0, if1.diff, if1.bout}, {30'd0, e.diff[0], e.bout});
        chk("w1_done_cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (if16.done === 1'b1) begin
      if (q16.size() == 0) begin
        chk("w16_unexpected_done", 32'd1, 32'd0);
      end else begin
        e = q16.pop_front();
        chk("w16_result", {15'd0, if16.bout, if16.diff}, {15'd0, e.bout, e.diff});
        chk("w16_done_cycle", cyc, e.cyc);
      end
    end
  end

  // ---------------- drivers ----------------
  // Called at a negedge; the following posedge is the accepting edge.
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                        input logic [7:0] ed, input logic eb, input bit push);
    exp_t e;
    if (push) begin
      e.cyc = cyc + 1 + 8; e.bout = eb; e.diff = {8'h00, ed};
      q8.push_back(e);
    end
    if8.start = 1'b1; if8.a = a; if8.b = b; if8.bin = bi;
    @(negedge clk);
    if8.start = 1'b0;
  endtask

  task automatic issue1(input logic a, input logic b, input logic bi,
                        input logic ed, input logic eb);
    exp_t e;
    e.cyc = cyc + 1 + 1; e.bout = eb; e.diff = {15'd0, ed};
    q1.push_back(e);
    if1.start = 1'b1; if1.a = a; if1.b = b; if1.bin = bi;
    @(negedge clk);
    if1.start = 1'b0;
  endtask

  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic bi);
    exp_t        e;
    logic [16:0] r;
    r = {1'b0, a} - {1'b0, b} - {16'd0, bi};
    e.cyc = cyc + 1 + 16; e.bout = r[16]; e.diff = r[15:0];
    q16.push_back(e);
    if16.start = 1'b1; if16.a = a; if16.b = b; if16.bin = bi;
    @(negedge clk);
    if16.start = 1'b0;
  endtask

  task automatic wait_done8();
    int k = 0;
    while (if8.done !== 1'b1 && k < 64) begin
      @(negedge clk);
      k++;
    end
    chk("w8_done_seen", {31'd0, if8.done}, 32'd1);
  endtask

  task automatic wait_done1();
    int k = 0;
    while (if1.done !== 1'b1 && k < 16) begin
      @(negedge clk);
      k++;
    end
    chk("w1_done_seen", {31'd0, if1.done}, 32'd1);
  endtask

  task automatic wait_done16();
    int k = 0;
    while (if16.done !== 1'b1 && k < 64) begin
      @(negedge clk);
      k++;
    end
    chk("w16_done_seen", {31'd0, if16.done}, 32'd1);
  endtask

  // {diff, bout} for {a, b, bin} = 000 .. 111
  logic [1:0] w1_tab [8] = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};

  initial begin
    #900000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] v;
    rst_n = 1'b0;
    if8.start  = 1'b0; if8.a  = '0; if8.b  = '0; if8.bin  = 1'b0;
    if1.start  = 1'b0; if1.a  = '0; if1.b  = '0; if1.bin  = 1'b0;
    if16.start = 1'b0; if16.a = '0; if16.b = '0; if16.bin = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_busy", {31'd0, if8.busy}, 32'd0);
    chk("rst_done", {31'd0, if8.done}, 32'd0);
    chk("rst_diff", {24'd0, if8.diff}, 32'd0);
    chk("rst_bout", {31'd0, if8.bout}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic: 0x5A - 0x3C = 0x1E, busy for exactly 8 cycles
    issue8(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b1);
    chk("basic_busy_e0", {31'd0, if8.busy}, 32'd1);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      chk("basic_busy_run", {31'd0, if8.busy}, 32'd1);
      chk("basic_no_early_done", {31'd0, if8.done}, 32'd0);
    end
    @(negedge clk);
    chk("basic_done_pulse", {31'd0, if8.done}, 32'd1);
    chk("basic_busy_end", {31'd0, if8.busy}, 32'd0);
    @(negedge clk);
    chk("basic_done_one_cycle", {31'd0, if8.done}, 32'd0);
    chk("basic_diff_held", {24'd0, if8.diff}, 32'h1E);

    // Borrow cases
    issue8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b1);
    wait_done8();
    @(negedge clk);
    issue8(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b1);
    wait_done8();
    @(negedge clk);
    issue8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b1);
    wait_done8();
    @(negedge clk);

    // Start pulsed mid-run with other operands is ignored
    issue8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    issue8(8'h01, 8'h02, 1'b1, 8'h00, 1'b0, 1'b0);
    wait_done8();
    repeat (12) @(negedge clk);
    chk("ignored_start_idle", {31'd0, if8.busy}, 32'd0);

    // Back-to-back: start held on the done cycle
    issue8(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b1);
    wait_done8();
    issue8(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b1);
    chk("b2b_busy", {31'd0, if8.busy}, 32'd1);
    chk("b2b_done_drop", {31'd0, if8.done}, 32'd0);
    chk("b2b_diff_hold0", {23'd0, if8.bout, if8.diff}, {23'd0, 1'b1, 8'hFF});
    repeat (4) @(negedge clk);
    chk("b2b_diff_hold1", {23'd0, if8.bout, if8.diff}, {23'd0, 1'b1, 8'hFF});
    wait_done8();
    issue8(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b1);
    chk("b2b2_diff_hold", {24'd0, if8.diff}, 32'h00);
    wait_done8();
    @(negedge clk);

    // Reset three cycles after start, with start asserted during reset
    issue8(8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    if8.start = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", {31'd0, if8.busy}, 32'd0);
    chk("mid_rst_done", {31'd0, if8.done}, 32'd0);
    chk("mid_rst_diff", {24'd0, if8.diff}, 32'd0);
    chk("mid_rst_bout", {31'd0, if8.bout}, 32'd0);
    rst_n = 1'b1;
    if8.start = 1'b0;
    @(negedge clk);
    chk("post_rst_start_ignored", {31'd0, if8.busy}, 32'd0);
    repeat (20) @(negedge clk);

    // WIDTH=1 exhaustive truth table
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      issue1(v[2], v[1], v[0], w1_tab[i][1], w1_tab[i][0]);
      wait_done1();
      @(negedge clk);
    end

    // WIDTH=16 random regression with random gaps, including back-to-back
    for (int i = 0; i < 1000; i++) begin
      issue16(16'($urandom), 16'($urandom), 1'($urandom));
      wait_done16();
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (4) @(negedge clk);

    chk("w8_queue_empty", q8.size(), 32'd0);
    chk("w1_queue_empty", q1.size(), 32'd0);
    chk("w16_queue_empty", q16.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Parametrised bit-serial N-bit subtractor computing `diff = a - b - bin` with a borrow-out, LSB first, one bit per clock. It reuses the single-bit full-subtractor equations with a registered borrow. A start/done handshake wraps the datapath. It is the sequential, width-generalised successor to the combinational 1-bit full subtractor, for designs that trade latency for area.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range is 1 or greater.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset is synchronous and active-low.
- `start` input 1: request a subtraction; sampled only in IDLE.
- `a` input WIDTH: minuend; latched on the accepting edge.
- `b` input WIDTH: subtrahend; latched on the accepting edge.
- `bin` input 1: borrow-in; latched on the accepting edge.
- `busy` output 1: high while an operation is in progress (RUN state).
- `done` output 1: one-cycle pulse when a result becomes valid.
- `diff` output WIDTH: result `(a - b - bin) mod 2^WIDTH`; holds the last completed result.
- `bout` output 1: final borrow-out, 1 when `a < b + bin` (unsigned); holds with `diff`.

## Operation
- States: IDLE, RUN.
- **Reset.** `rst_n` low at a rising edge puts the block in IDLE.
  - `busy`, `done`, `diff`, `bout`, the internal shift registers, the borrow register and the bit counter all go to 0.
  - Reset takes priority over all other inputs.
- **IDLE.**
  - If `start` is 1, latch `a`, `b` and `bin` into the shift registers and the borrow register.
  - Clear the bit counter, go to RUN and set `busy` to 1.
  - Otherwise hold state.
- **RUN, once per clock.** With `x` = a_sh[0], `y` = b_sh[0] and `br` = the borrow register:
  - Result bit `d` = x ^ y ^ br.
  - Next borrow = (~x & y) | (~(x ^ y) & br).
  - Shift `d` into the MSB of the result shift register, which moves right.
  - Shift a_sh and b_sh right by 1.
  - Increment the counter.
- **Completion.** On the WIDTH-th RUN edge:
  - Copy the completed result shift register into `diff` and the final borrow into `bout`.
  - Set `done` to 1, clear `busy` and return to IDLE.
- `diff` and `bout` change only on completion edges and on reset. They never show partial results.
- `start` during RUN is ignored. The latched operands are unaffected by changes on `a`, `b` or `bin` during RUN.
- `done` is cleared on the next edge unless a new completion occurs on that edge.
- The counter is `$clog2(WIDTH+1)` bits wide. It must not wrap before reaching WIDTH.
- `WIDTH` = 1 degenerates to one RUN cycle and must match the 1-bit full-subtractor truth table.

## Timing
- Start accepted at edge E0 (IDLE with `start` = 1):
  - `busy` is 1 from E0 through E(WIDTH−1).
  - Result bits are computed at edges E1 through EWIDTH.
  - At EWIDTH: `diff` and `bout` become valid, `done` goes to 1 and `busy` goes to 0.
- Latency: WIDTH clocks from the accepting edge to `done`.
- Throughput: one operation per WIDTH+1 clocks.
- Back-to-back operation:
  - `start` held high in the cycle where `done` = 1 is accepted, because the block is in IDLE.
  - Busy goes back to 1 on the next edge and `done` drops.
  - `diff` and `bout` keep the previous result until the new completion.
- Reset mid-RUN:
  - The operation is aborted, with no `done` pulse.
  - All outputs read 0 after the reset edge.
  - A `start` sampled while `rst_n` is low is ignored.

## Test plan
- **Basic subtraction (WIDTH=8).** Start with a=0x5A, b=0x3C, bin=0.
  - Expect `busy` high for 8 cycles, then a one-cycle `done`.
  - Result: diff=0x1E, bout=0.
- **Borrow cases (WIDTH=8).**
  - a=0x00, b=0x01, bin=0 gives diff=0xFF, bout=1.
  - a=0x10, b=0x0F, bin=1 gives diff=0x00, bout=0.
  - a=0xFF, b=0xFF, bin=1 gives diff=0xFF, bout=1.
- **Protocol (WIDTH=8).**
  - Pulse `start` again mid-RUN with different operands: it is ignored, and the original result is delivered at the original time.
  - Hold `start` high on the `done` cycle: the next operation begins with no idle gap, and `diff` holds the old value until the next `done`.
- **Reset mid-operation.** Drop `rst_n` low 3 cycles after start.
  - Expect busy=0, done=0, diff=0x00, bout=0 after the edge.
  - No `done` pulse appears afterwards.
- **WIDTH=1 exhaustive.** Run all 8 combinations of {a, b, bin}.
  - Expected (diff, bout) in order 000→111: 00, 11, 11, 01, 10, 00, 00, 11.
  - Each `done` arrives 1 cycle after its start.
- **WIDTH=16 random regression.** 1000 random operands compared against a reference model of `{bout, diff} = a - b - bin`.
  - Random `start` gaps, including back-to-back starts.
